// File: rtl/secded_dec_engine.sv
// secded_dec_engine: reads Hamming(16,11) SECDED words from data memory,
// corrects single-bit errors, flags double-bit errors, and writes the
// 11-bit message plus two status flags back. Per-run error counts are kept.
//
// Outputs are registered. The next-cycle address, strobe and write data are
// computed from the next state, so each output is valid during the state it
// belongs to. Decode runs on the captured word. While in RD_HI, the high byte
// is taken straight from mem_rd_data, so the WR_LO data can be registered on
// the same edge that captures it.

module secded_dec_engine #(
    parameter int unsigned NUM_WORDS = 15,
    parameter int unsigned SRC_BASE  = 30,
    parameter int unsigned DST_BASE  = 0,
    parameter int unsigned AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [4:0]    n_single,
    output logic [4:0]    n_double
);

    localparam int unsigned IW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CW  = 5;
    localparam int unsigned MW  = 11;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    // Hamming positions of message bits d1..d11 (non-powers of two)
    localparam int unsigned DPOS [MW] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    hi_q, hi_d;
    logic [CW-1:0] nsgl_d, ndbl_d;
    logic          done_d, busy_d, wr_en_d;
    logic [AW-1:0] addr_d;
    logic [7:0]    wr_data_d;

    logic [15:0]   word_c;
    logic [3:0]    syn_c;
    logic          par_c;
    logic          single_c;
    logic          double_c;
    logic [MW-1:0] msg_c;
    logic [7:0]    dec_lo_c;
    logic [7:0]    dec_hi_c;

    // Word to decode: the high byte bypasses its capture register while it is being read
    assign word_c = {(state_q == RD_HI) ? mem_rd_data : hi_q, lo_q};

    // Syndrome, overall parity, correction and output byte formatting
    always_comb begin
        syn_c    = '0;
        par_c    = 1'b0;
        msg_c    = '0;
        syn_c[3] = ^word_c[15:8];
        syn_c[2] = ^{word_c[15:12], word_c[7:4]};
        syn_c[1] = ^{word_c[15:14], word_c[11:10], word_c[7:6], word_c[3:2]};
        syn_c[0] = ^{word_c[15], word_c[13], word_c[11], word_c[9],
                     word_c[7],  word_c[5],  word_c[3],  word_c[1]};
        par_c    = ^word_c;
        single_c = par_c;
        double_c = !par_c && (syn_c != 4'd0);
        // A data bit flips only when parity is odd and the syndrome points at it
        for (int j = 0; j < int'(MW); j++) begin
            msg_c[j] = word_c[DPOS[j]] ^ (par_c && (syn_c == 4'(DPOS[j])));
        end
        dec_lo_c = msg_c[7:0];
        dec_hi_c = {double_c, single_c, 3'b000, msg_c[10:8]};
    end

    // Next-state, capture, counter and next-output logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        nsgl_d    = n_single;
        ndbl_d    = n_double;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        addr_d    = '0;
        wr_en_d   = 1'b0;
        wr_data_d = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_LO;
                    idx_d   = '0;
                    nsgl_d  = '0;
                    ndbl_d  = '0;
                end
            end
            RD_LO: begin
                lo_d    = mem_rd_data;
                state_d = RD_HI;
            end
            RD_HI: begin
                hi_d    = mem_rd_data;
                state_d = WR_LO;
            end
            WR_LO: begin
                state_d = WR_HI;
            end
            WR_HI: begin
                if (single_c && (n_single != CNT_MAX)) begin
                    nsgl_d = n_single + CW'(1);
                end
                if (double_c && (n_double != CNT_MAX)) begin
                    ndbl_d = n_double + CW'(1);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RD_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE) && (state_d != DONE);

        case (state_d)
            RD_LO: begin
                addr_d = AW'(SRC_BASE) + (AW'(idx_d) << 1);
            end
            RD_HI: begin
                addr_d = AW'(SRC_BASE) + (AW'(idx_d) << 1) + AW'(1);
            end
            WR_LO: begin
                addr_d    = AW'(DST_BASE) + (AW'(idx_d) << 1);
                wr_en_d   = 1'b1;
                wr_data_d = dec_lo_c;
            end
            WR_HI: begin
                addr_d    = AW'(DST_BASE) + (AW'(idx_d) << 1) + AW'(1);
                wr_en_d   = 1'b1;
                wr_data_d = dec_hi_c;
            end
            default: begin
                addr_d = '0;
            end
        endcase
    end

    // State, capture, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            n_single    <= '0;
            n_double    <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            n_single    <= nsgl_d;
            n_double    <= ndbl_d;
            done        <= done_d;
            busy        <= busy_d;
            mem_addr    <= addr_d;
            mem_wr_en   <= wr_en_d;
            mem_wr_data <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_secded_dec_engine.sv
// Self-checking bench for secded_dec_engine: behavioural memory, position-based
// Hamming encoder/decoder reference, directed and randomized runs.

module tb_secded_dec_engine;

    localparam int unsigned NW  = 15;
    localparam int unsigned SRC = 30;
    localparam int unsigned DST = 0;
    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 4 * NW;

    logic          clk;
    logic          reset;
    logic          start;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [4:0]    n_single;
    logic [4:0]    n_double;

    logic [7:0]    mem [256];
    logic          tb_we;
    logic [7:0]    tb_addr;
    logic [7:0]    tb_data;

    int            checks = 0;
    int            errors = 0;

    logic [15:0]   words   [NW];
    logic [7:0]    exp_mem [2*NW];
    int            exp_single;
    int            exp_double;
    int            exp_clean;

    secded_dec_engine #(
        .NUM_WORDS (NW),
        .SRC_BASE  (SRC),
        .DST_BASE  (DST),
        .AW        (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .n_single    (n_single),
        .n_double    (n_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read, write at the clock edge; bench preload has priority
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_write(input int unsigned a, input logic [7:0] d);
        tb_we   = 1'b1;
        tb_addr = 8'(a);
        tb_data = d;
        tick();
        tb_we   = 1'b0;
    endtask

    function automatic bit is_pow2(input int k);
        return (k & (k - 1)) == 0;
    endfunction

    // Golden encoder: data in non-power-of-two positions, parity makes syndrome zero
    function automatic logic [15:0] encode(input logic [10:0] msg);
        logic [15:0] w;
        int j;
        int syn;
        w = '0;
        j = 0;
        syn = 0;
        for (int k = 3; k < 16; k++) begin
            if (!is_pow2(k)) begin
                w[k] = msg[j];
                j++;
            end
        end
        for (int k = 1; k < 16; k++) if (w[k]) syn = syn ^ k;
        for (int b = 0; b < 4; b++) w[1 << b] = ((syn >> b) & 1) != 0;
        w[0] = ^w[15:1];
        return w;
    endfunction

    // Reference decoder: syndrome is the XOR of the positions of set bits
    task automatic ref_decode(input logic [15:0] w, output logic [7:0] lo,
                              output logic [7:0] hi, output int kind);
        logic [15:0] c;
        logic [10:0] msg;
        int syn;
        int ones;
        int j;
        c = w;
        syn = 0;
        ones = 0;
        msg = '0;
        for (int k = 0; k < 16; k++) begin
            if (w[k]) begin
                ones++;
                syn = syn ^ k;
            end
        end
        if ((ones % 2) == 1) begin
            kind = 1;
            c[syn] = ~c[syn];
        end else if (syn != 0) begin
            kind = 2;
        end else begin
            kind = 0;
        end
        j = 0;
        for (int k = 3; k < 16; k++) begin
            if (!is_pow2(k)) begin
                msg[j] = c[k];
                j++;
            end
        end
        lo = msg[7:0];
        hi = {1'(kind == 2), 1'(kind == 1), 3'b000, msg[10:8]};
    endtask

    // Load source words, poison destination, build expected image and counts
    task automatic prepare();
        logic [7:0] lo;
        logic [7:0] hi;
        int kind;
        exp_single = 0;
        exp_double = 0;
        exp_clean  = 0;
        for (int i = 0; i < int'(NW); i++) begin
            mem_write(SRC + 2*i, words[i][7:0]);
            mem_write(SRC + 2*i + 1, words[i][15:8]);
            mem_write(DST + 2*i, 8'hEE);
            mem_write(DST + 2*i + 1, 8'hEE);
            ref_decode(words[i], lo, hi, kind);
            exp_mem[2*i]     = lo;
            exp_mem[2*i + 1] = hi;
            if (kind == 1) exp_single++;
            else if (kind == 2) exp_double++;
            else exp_clean++;
        end
    endtask

    task automatic fill_clean_tail();
        for (int i = 1; i < int'(NW); i++) words[i] = encode(11'($urandom));
    endtask

    // Pulse start, optionally poke start while busy, wait for done with a bound
    task automatic run(input bit noisy, output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 400) begin
            start = noisy && (cyc < 55) && ($urandom_range(0, 7) == 0);
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int cyc);
        check({tag, " latency"}, 32'(cyc), 32'(LAT));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " n_single"}, 32'(n_single), 32'(exp_single));
        check({tag, " n_double"}, 32'(n_double), 32'(exp_double));
        for (int a = 0; a < 2*int'(NW); a++)
            check($sformatf("%s dst[%0d]", tag, a), 32'(mem[DST + a]), 32'(exp_mem[a]));
    endtask

    task automatic directed(input string tag, input logic [15:0] w0, input logic [7:0] b0,
                            input logic [7:0] b1, input int ns, input int nd);
        int cyc;
        words[0] = w0;
        fill_clean_tail();
        prepare();
        run(1'b0, cyc);
        check({tag, " byte0"}, 32'(mem[DST]), 32'(b0));
        check({tag, " byte1"}, 32'(mem[DST + 1]), 32'(b1));
        check({tag, " n_single const"}, 32'(n_single), 32'(ns));
        check({tag, " n_double const"}, 32'(n_double), 32'(nd));
        check_run(tag, cyc);
    endtask

    initial begin
        int cyc;
        int b1;
        int b2;
        reset   = 1'b1;
        start   = 1'b0;
        tb_we   = 1'b0;
        tb_addr = '0;
        tb_data = '0;
        tick();
        tick();
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset wr_en", 32'(mem_wr_en), 32'd0);
        check("reset addr", 32'(mem_addr), 32'd0);
        check("reset wr_data", 32'(mem_wr_data), 32'd0);
        check("reset n_single", 32'(n_single), 32'd0);
        check("reset n_double", 32'(n_double), 32'd0);
        reset = 1'b0;
        tick();
        check("idle addr", 32'(mem_addr), 32'd0);

        directed("clean",  16'hB42D, 8'hA3, 8'h05, 0, 0);
        directed("sgl_d",  16'hB02D, 8'hA3, 8'h45, 1, 0);
        directed("sgl_p0", 16'hB42C, 8'hA3, 8'h45, 1, 0);
        directed("double", 16'hB025, 8'h82, 8'h85, 0, 1);

        // Mixed traffic: 75% single flips, 25% double flips, start noise while busy
        for (int i = 0; i < int'(NW); i++) begin
            words[i] = encode(11'($urandom));
            b1 = $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0) begin
                words[i][b1] = ~words[i][b1];
            end else begin
                b2 = (b1 + $urandom_range(1, 15)) % 16;
                words[i][b1] = ~words[i][b1];
                words[i][b2] = ~words[i][b2];
            end
        end
        prepare();
        run(1'b1, cyc);
        check_run("mixed", cyc);
        check("mixed total", 32'(n_single) + 32'(n_double) + 32'(exp_clean), 32'(NW));

        // Reset mid-run, held together with start: reset wins, no further writes
        prepare();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("midrun busy", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst wr_en", 32'(mem_wr_en), 32'd0);
        check("rst addr", 32'(mem_addr), 32'd0);
        check("rst n_single", 32'(n_single), 32'd0);
        check("rst n_double", 32'(n_double), 32'd0);
        reset = 1'b0;
        tick();
        check("post rst busy", 32'(busy), 32'd0);
        for (int a = 0; a < 4; a++)
            check($sformatf("rst written dst[%0d]", a), 32'(mem[DST + a]), 32'(exp_mem[a]));
        for (int a = 4; a < 2*int'(NW); a++)
            check($sformatf("rst untouched dst[%0d]", a), 32'(mem[DST + a]), 32'h0EE);
        run(1'b0, cyc);
        check_run("after_rst", cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_dec_engine.md
Name: secded_dec_engine

Overview:
- Hardware decode stage for the Hamming(16,11) SECDED words that the program-1 encoder writes to data memory. It is the downstream consumer of that encoder.
- After a start pulse, it reads NUM_WORDS encoded words from data memory, computes syndrome and overall parity, and corrects single-bit errors. Double-bit errors are flagged, not corrected.
- It writes the 11-bit message plus 2 status flags back to memory and keeps per-run error counts.
- It shares the single data-memory port with the core while the core is idle.

Parameters:
- NUM_WORDS, 15, number of words decoded per run.
- SRC_BASE, 30, byte address of the first encoded word's low byte.
- DST_BASE, 0, byte address of the first decoded word's low byte.
- AW, 8, data-memory address width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- done  output  1  high while in DONE.
- busy  output  1  high in every state other than IDLE and DONE.
- mem_addr  output  AW  data-memory byte address.
- mem_rd_data  input  8  combinational (same-cycle) read data at mem_addr.
- mem_wr_en  output  1  write strobe; memory writes mem_wr_data at the clock edge.
- mem_wr_data  output  8  write data.
- n_single  output  5  count of single-error words this run.
- n_double  output  5  count of double-error words this run.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values: state IDLE; word index i=0; done=0, busy=0, mem_wr_en=0; mem_addr=0, mem_wr_data=0; n_single=0, n_double=0; capture registers cleared.
- Encoded word layout: word bit k is Hamming position k. w[15:0] = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}. Low byte is at SRC_BASE+2i; high byte is at SRC_BASE+2i+1.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. Each state lasts exactly one cycle.
- IDLE or DONE with start=1 goes to RD_LO. The same edge sets i=0 and clears both counters.
- RD_LO: mem_addr=SRC_BASE+2i; latch mem_rd_data as the low byte.
- RD_HI: mem_addr=SRC_BASE+2i+1; latch the high byte.
- WR_LO: mem_addr=DST_BASE+2i; mem_wr_en=1; mem_wr_data = corrected d8..d1.
- WR_HI: mem_addr=DST_BASE+2i+1; mem_wr_en=1; mem_wr_data = {F1, F0, 3'b000, d11..d9}. Counters update on this edge.
- After WR_HI: if i==NUM_WORDS-1, go to DONE; otherwise increment i and go to RD_LO.
- Decode is combinational from the captured word during WR_LO and WR_HI.
  - s[3] = ^w[15:8].
  - s[2] = ^{w[15:12], w[7:4]}.
  - s[1] = XOR of bits 15,14,11,10,7,6,3,2.
  - s[0] = XOR of odd bits.
  - P = ^w[15:0].
- Decode cases:
  - P=0, s=0: no error; F=00.
  - P=1: single error. Flip bit s (s=0 means p0; data unchanged). F=01; n_single increments.
  - P=0, s≠0: double error. Data is extracted raw, uncorrected. F=10; n_double increments.
- Counters saturate at 31 and hold their value in DONE.
- Latency: start sampled at edge 0 gives done=1 after edge 4·NUM_WORDS (60 by default). done stays high until start is accepted or reset.
- mem_wr_en=0 in every state other than WR_LO and WR_HI. mem_addr=0 in IDLE and DONE.
- start while busy is ignored and has no effect on the run.
- Reset mid-run returns to IDLE on the next edge with no further writes. Bytes already written remain in memory.
- start and reset high together: reset wins.
- Address arithmetic is AW bits wide, with no wrap checking. Integration keeps the source and destination ranges disjoint.

Test Plan:
- Clean word: source bytes 0x2D (addr 30), 0xB4 (addr 31), message 0x5A3, start -> addr0=0xA3, addr1=0x05; n_single=0, n_double=0; done high 60 cycles after start.
- Single error in data bit: word 0xB02D (bit 10 flipped) -> addr0=0xA3, addr1=0x45; n_single=1.
- Single error in p0: word 0xB42C -> addr0=0xA3, addr1=0x45. The data is not altered.
- Double error: word 0xB025 (bits 10 and 3 flipped) -> addr0=0x82, addr1=0x85; n_double=1.
- Full run with mixed traffic: 15 random messages encoded by the golden model, 75% with one flip, 25% with two flips. All 30 destination bytes must match the reference decoder, and n_single+n_double+clean=15. Start pulses during busy are ignored.
- Reset mid-run: assert reset in cycle 10 -> next edge busy=0, done=0, counters=0, mem_wr_en=0. Bytes 0..3 already written and bytes 4..29 untouched. A subsequent start completes normally.
